// File: rtl/e1_pkg.sv
// ---------------------------------------------------------------------------
// e1_pkg
// Shared constants and types for the E1 receive framer.
//   E1_FAS            : frame alignment signal, TS0 bits 2..8 of even frames
//   E1_TS_PER_FRAME   : time slots per frame
//   E1_BITS_PER_FRAME : bits per frame
//   E1_POS_TS0_END    : double-frame position of the last bit of TS0
//   e1_sync_state_t   : alignment state machine states
// ---------------------------------------------------------------------------
package e1_pkg;

    localparam logic [6:0] E1_FAS            = 7'b0011011;
    localparam int         E1_TS_PER_FRAME   = 32;
    localparam int         E1_BITS_PER_FRAME = 256;
    localparam logic [8:0] E1_POS_TS0_END    = 9'd7;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        FAS_SEEN = 2'd1,
        CONFIRM  = 2'd2,
        SYNC     = 2'd3
    } e1_sync_state_t;

endpackage

// File: rtl/e1_deser8.sv
// ---------------------------------------------------------------------------
// e1_deser8
// Serial-to-octet shift register plus double-frame bit position counter.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_bit_en    : qualifies i_bit_in
//   i_bit_in    : serial data, MSB of each octet first
//   i_load      : with i_bit_en, marks the current bit as the end of TS0
//   o_octet     : octet completed by the current bit, {sh[6:0], i_bit_in}
//   o_pos       : double-frame position (0..511) of the current bit
// ---------------------------------------------------------------------------
module e1_deser8
    import e1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_bit_en,
    input  logic       i_bit_in,
    input  logic       i_load,
    output logic [7:0] o_octet,
    output logic [8:0] o_pos
);

    logic [7:0] r_sh;
    logic [8:0] r_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= 8'd0;
            r_pos <= 9'd0;
        end else if (i_bit_en) begin
            r_sh <= {r_sh[6:0], i_bit_in};
            // r_pos names the bit being received; a load declares the current
            // bit to be position 7, so the following bit is position 8.
            if (i_load) begin
                r_pos <= E1_POS_TS0_END + 9'd1;
            end else begin
                r_pos <= r_pos + 9'd1;
            end
        end
    end

    assign o_octet = {r_sh[6:0], i_bit_in};
    assign o_pos   = r_pos;

endmodule

// File: rtl/e1_frame_sync.sv
// ---------------------------------------------------------------------------
// e1_frame_sync
// E1 receive frame aligner and deserializer. Hunts for the FAS in TS0,
// verifies it with the NFAS bit of the odd frame and a second FAS, then
// delivers every octet with its time-slot number.
// Optional build macro: E1_SYNC_STATS_EN adds saturating FAS / NFAS error
// counters (fas_err_cnt, nfas_err_cnt) counted while aligned.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bit_en       : qualifies bit_in (continuous or gapped)
//   bit_in       : serial E1 data, bit 1 of each octet first
//   byte_out     : received octet, bit 1 in [7]
//   ts_num       : time slot of byte_out
//   byte_valid   : one-cycle pulse when byte_out/ts_num update
//   frame_start  : byte_valid for time slot 0
//   sync         : frame alignment achieved
//   fas_err_cnt  : FAS mismatches while aligned (E1_SYNC_STATS_EN only)
//   nfas_err_cnt : NFAS bit 2 = 0 events while aligned (E1_SYNC_STATS_EN only)
// ---------------------------------------------------------------------------
module e1_frame_sync
    import e1_pkg::*;
#(
    parameter logic [6:0] FAS_WORD   = E1_FAS,
    parameter int         LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [7:0]  byte_out,
    output logic [4:0]  ts_num,
    output logic        byte_valid,
    output logic        frame_start,
    output logic        sync
`ifdef E1_SYNC_STATS_EN
    ,
    output logic [15:0] fas_err_cnt,
    output logic [15:0] nfas_err_cnt
`endif
);

    localparam logic [8:0] POS_FAS  = E1_POS_TS0_END;
    localparam logic [8:0] POS_NFAS = 9'(E1_BITS_PER_FRAME) + E1_POS_TS0_END;
    localparam int         RUN_W    = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOSS_COUNT - 1);

    logic [7:0]       w_octet;
    logic [8:0]       w_pos;
    logic             w_fas_ok;
    logic             w_load;
    logic             w_deliver;
    logic             w_fas_bad;
    logic             w_nfas_bad;
    e1_sync_state_t   w_state_next;
    logic [RUN_W-1:0] w_run_next;

    e1_sync_state_t   r_state;
    logic [RUN_W-1:0] r_run;
    logic [7:0]       r_byte_out;
    logic [4:0]       r_ts_num;
    logic             r_byte_valid;
    logic             r_frame_start;
    logic             r_sync;

    e1_deser8 u_deser (
        .clk      (clk),
        .rst      (rst),
        .i_bit_en (bit_en),
        .i_bit_in (bit_in),
        .i_load   (w_load),
        .o_octet  (w_octet),
        .o_pos    (w_pos)
    );

    // The Si bit (octet [7]) takes no part in alignment.
    assign w_fas_ok = (w_octet[6:0] == FAS_WORD);

    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        w_load       = 1'b0;
        w_deliver    = 1'b0;
        w_fas_bad    = 1'b0;
        w_nfas_bad   = 1'b0;
        if (bit_en) begin
            case (r_state)
                HUNT: begin
                    if (w_fas_ok) begin
                        w_load       = 1'b1;
                        w_state_next = FAS_SEEN;
                    end
                end
                FAS_SEEN: begin
                    if (w_pos == POS_NFAS) begin
                        w_state_next = w_octet[6] ? CONFIRM : HUNT;
                    end
                end
                CONFIRM: begin
                    if (w_pos == POS_FAS) begin
                        if (w_fas_ok) begin
                            w_state_next = SYNC;
                            w_deliver    = 1'b1;   // TS0 of the confirming frame
                        end else begin
                            w_state_next = HUNT;
                        end
                    end
                end
                SYNC: begin
                    // Every octet end delivers, including the one that loses sync.
                    w_deliver = (w_pos[2:0] == 3'd7);
                    if (w_pos == POS_FAS) begin
                        if (w_fas_ok) begin
                            w_run_next = '0;
                        end else begin
                            w_fas_bad = 1'b1;
                            if (r_run == RUN_LAST) begin
                                w_state_next = HUNT;
                                w_run_next   = '0;
                            end else begin
                                w_run_next = r_run + 1'b1;
                            end
                        end
                    end
                    if ((w_pos == POS_NFAS) && !w_octet[6]) begin
                        w_nfas_bad = 1'b1;
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_run         <= '0;
            r_byte_out    <= 8'd0;
            r_ts_num      <= 5'd0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_run         <= w_run_next;
            r_byte_valid  <= w_deliver;
            r_frame_start <= w_deliver && (w_pos[7:3] == 5'd0);
            r_sync        <= (w_state_next == SYNC);
            if (w_deliver) begin
                r_byte_out <= w_octet;
                r_ts_num   <= w_pos[7:3];
            end
        end
    end

    assign byte_out    = r_byte_out;
    assign ts_num      = r_ts_num;
    assign byte_valid  = r_byte_valid;
    assign frame_start = r_frame_start;
    assign sync        = r_sync;

`ifdef E1_SYNC_STATS_EN
    logic [15:0] r_fas_err_cnt;
    logic [15:0] r_nfas_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fas_err_cnt  <= 16'd0;
            r_nfas_err_cnt <= 16'd0;
        end else begin
            if (w_fas_bad && (r_fas_err_cnt != 16'hFFFF)) begin
                r_fas_err_cnt <= r_fas_err_cnt + 16'd1;
            end
            if (w_nfas_bad && (r_nfas_err_cnt != 16'hFFFF)) begin
                r_nfas_err_cnt <= r_nfas_err_cnt + 16'd1;
            end
        end
    end

    assign fas_err_cnt  = r_fas_err_cnt;
    assign nfas_err_cnt = r_nfas_err_cnt;
`endif

endmodule

// File: tb/tb_e1_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_e1_frame_sync
// Bench for e1_frame_sync. Each scenario builds a bit stream, derives the
// expected per-bit outputs from the framing rules applied to the whole
// stream, resets the design and plays the stream in.
// ---------------------------------------------------------------------------
module tb_e1_frame_sync;

    localparam logic [6:0] FAS  = 7'b0011011;
    localparam int         LOSS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_en;
    logic        bit_in;
    logic [7:0]  byte_out;
    logic [4:0]  ts_num;
    logic        byte_valid;
    logic        frame_start;
    logic        sync;
`ifdef E1_SYNC_STATS_EN
    logic [15:0] fas_err_cnt;
    logic [15:0] nfas_err_cnt;
`endif

    always #5 clk = ~clk;

    e1_frame_sync dut (
        .clk          (clk),
        .rst          (rst),
        .bit_en       (bit_en),
        .bit_in       (bit_in),
        .byte_out     (byte_out),
        .ts_num       (ts_num),
        .byte_valid   (byte_valid),
        .frame_start  (frame_start),
        .sync         (sync)
`ifdef E1_SYNC_STATS_EN
        ,
        .fas_err_cnt  (fas_err_cnt),
        .nfas_err_cnt (nfas_err_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cur_bit = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at bit %0d: got 0x%0h expected 0x%0h", tag, cur_bit, got, exp);
        end
    endtask

    // ---------------- stream and reference model ----------------
    bit         bit_q[$];
    bit         exp_valid[];
    logic [7:0] exp_byte[];
    logic [4:0] exp_ts[];
    bit         exp_sync[];
    int         exp_fas_errs;
    int         exp_nfas_errs;

    function automatic bit bt(input int k);
        if (k < 0 || k >= bit_q.size()) return 1'b0;
        return bit_q[k];
    endfunction

    // Octet whose last bit is stream bit k (bits before the stream are 0).
    function automatic logic [7:0] octet_at(input int k);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[7-i] = bt(k - 7 + i);
        return o;
    endfunction

    function automatic bit fas_at(input int k);
        logic [7:0] o;
        o = octet_at(k);
        return o[6:0] == FAS;
    endfunction

    function automatic bit nfas_at(input int k);
        logic [7:0] o;
        o = octet_at(k);
        return o[6];
    endfunction

    task automatic build_model();
        int n, k, c, s, j, d, run, stop;
        n = bit_q.size();
        exp_valid = new[n];
        exp_byte  = new[n];
        exp_ts    = new[n];
        exp_sync  = new[n];
        for (int i = 0; i < n; i++) begin
            exp_valid[i] = 1'b0;
            exp_byte[i]  = 8'd0;
            exp_ts[i]    = 5'd0;
            exp_sync[i]  = 1'b0;
        end
        exp_fas_errs  = 0;
        exp_nfas_errs = 0;
        k = 0;
        while (k < n) begin
            // first FAS candidate at or after k
            c = -1;
            for (int x = k; x < n; x++) begin
                if (fas_at(x)) begin
                    c = x;
                    break;
                end
            end
            if (c < 0 || c + 256 >= n) break;
            if (!nfas_at(c + 256)) begin
                k = c + 257;
                continue;
            end
            if (c + 512 >= n) break;
            if (!fas_at(c + 512)) begin
                k = c + 513;
                continue;
            end
            // aligned: bit s ends TS0 of an even frame
            s    = c + 512;
            run  = 0;
            stop = n;
            for (j = s; j < n; j += 8) begin
                d = j - s;
                exp_valid[j] = 1'b1;
                exp_byte[j]  = octet_at(j);
                exp_ts[j]    = 5'((d / 8) % 32);
                if (d % 512 == 0 && d != 0) begin
                    if (!fas_at(j)) begin
                        exp_fas_errs++;
                        run++;
                        if (run == LOSS) begin
                            stop = j;
                            break;
                        end
                    end else begin
                        run = 0;
                    end
                end
                if (d % 512 == 256 && !nfas_at(j)) exp_nfas_errs++;
            end
            for (int x = s; x < stop; x++) exp_sync[x] = 1'b1;
            k = stop + 1;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_q.push_back(v[i]);
    endtask

    task automatic push_frame(input bit odd, input logic [7:0] ts0_xor, input bit rnd,
                              input int sp_ts, input logic [7:0] sp_val);
        logic [7:0] v;
        for (int ts = 0; ts < 32; ts++) begin
            if (ts == 0)          v = (odd ? 8'h40 : 8'h1B) ^ ts0_xor;
            else if (ts == sp_ts) v = sp_val;
            else if (rnd)         v = 8'($urandom);
            else                  v = 8'(ts);
            push_byte(v);
        end
    endtask

    // ---------------- driver / checker ----------------
    // gap: 1 = bit_en every cycle, N>1 = one cycle in N, 0 = random
    task automatic run_scenario(input string name, input int gap,
                                output int first_sync, output int drop_bit);
        int n, idx, pending, cyc;
        logic [7:0] held_b;
        logic [4:0] held_t;
        bit cur_sync, prev_dut_sync, en;
        build_model();
        n = bit_q.size();

        // reset, with bit_en asserted to show that reset wins
        @(negedge clk);
        rst = 1'b1; bit_en = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        rst = 1'b0; bit_en = 1'b0;
        cur_bit = -1;
        check_val("rst_byte_out",    32'(byte_out),    32'd0);
        check_val("rst_ts_num",      32'(ts_num),      32'd0);
        check_val("rst_byte_valid",  32'(byte_valid),  32'd0);
        check_val("rst_frame_start", 32'(frame_start), 32'd0);
        check_val("rst_sync",        32'(sync),        32'd0);
`ifdef E1_SYNC_STATS_EN
        check_val("rst_fas_cnt",     32'(fas_err_cnt), 32'd0);
        check_val("rst_nfas_cnt",    32'(nfas_err_cnt), 32'd0);
`endif

        idx = 0; pending = -1; cyc = 0;
        held_b = 8'd0; held_t = 5'd0;
        cur_sync = 1'b0; prev_dut_sync = 1'b0;
        first_sync = -1; drop_bit = -1;
        while (1) begin
            if (gap == 0)     en = ($urandom_range(0, 1) == 0);
            else              en = (cyc % gap == 0);
            if (idx < n && en) begin
                bit_en = 1'b1; bit_in = bit_q[idx]; pending = idx; idx++;
            end else begin
                bit_en = 1'b0; bit_in = 1'($urandom); pending = -1;
            end
            cyc++;
            @(negedge clk);
            if (pending >= 0) begin
                cur_bit = pending;
                check_val("byte_valid", 32'(byte_valid), 32'(exp_valid[pending]));
                check_val("frame_start", 32'(frame_start),
                          32'(exp_valid[pending] && exp_ts[pending] == 5'd0));
                if (exp_valid[pending]) begin
                    held_b = exp_byte[pending];
                    held_t = exp_ts[pending];
                end
                cur_sync = exp_sync[pending];
                if (sync === 1'b1 && first_sync < 0) first_sync = pending;
                if (sync === 1'b0 && prev_dut_sync && drop_bit < 0) drop_bit = pending;
            end else begin
                check_val("idle_byte_valid",  32'(byte_valid),  32'd0);
                check_val("idle_frame_start", 32'(frame_start), 32'd0);
            end
            check_val("byte_out", 32'(byte_out), 32'(held_b));
            check_val("ts_num",   32'(ts_num),   32'(held_t));
            check_val("sync",     32'(sync),     32'(cur_sync));
            prev_dut_sync = (sync === 1'b1);
            if (idx >= n && pending < 0) break;
            if (cyc > 40000) begin
                check_val("cycle_budget", 32'(cyc), 32'd40000);
                break;
            end
        end
`ifdef E1_SYNC_STATS_EN
        check_val("fas_err_cnt",  32'(fas_err_cnt),  32'(exp_fas_errs));
        check_val("nfas_err_cnt", 32'(nfas_err_cnt), 32'(exp_nfas_errs));
`endif
        $display("scenario %s: %0d bits in %0d cycles, sync at bit %0d, loss at bit %0d, fas errs %0d",
                 name, n, cyc, first_sync, drop_bit, exp_fas_errs);
    endtask

    initial begin
        int fs, dr, tries, plen;
        bit ok;
        logic [7:0] x;
        rst = 1'b1; bit_en = 1'b0; bit_in = 1'b0;

        // clean stream from reset
        bit_q.delete();
        for (int f = 0; f < 8; f++) push_frame(1'(f % 2), 8'h00, 1'b0, -1, 8'h00);
        run_scenario("clean", 1, fs, dr);
        check_val("clean_sync_bit", 32'(fs), 32'd519);

        // random prefix with no FAS look-alike ahead of the real one;
        // the reset here also lands in the middle of SYNC
        ok = 1'b0; tries = 0;
        while (!ok && tries < 100) begin
            bit_q.delete();
            repeat (37) bit_q.push_back(1'($urandom));
            for (int f = 0; f < 8; f++) push_frame(1'(f % 2), 8'h00, 1'b0, -1, 8'h00);
            ok = 1'b1;
            for (int i = 0; i < 44; i++) if (fas_at(i)) ok = 1'b0;
            tries++;
        end
        run_scenario("prefix37", 1, fs, dr);
        check_val("prefix_sync_bit", 32'(fs), 32'd556);

        // false FAS in TS5 of an odd frame, next frame's TS5 bit 2 is 0
        bit_q.delete();
        push_frame(1'b1, 8'h00, 1'b0, 5, 8'h1B);
        for (int f = 1; f < 10; f++) push_frame(1'((f + 1) % 2), 8'h00, 1'b0, -1, 8'h00);
        run_scenario("false_fas", 1, fs, dr);

        // FAS errors in SYNC: two then good (holds), then three (loses)
        bit_q.delete();
        for (int f = 0; f < 16; f++) begin
            if (f == 4 || f == 6 || f == 10 || f == 12 || f == 14) x = 8'h04;
            else if (f == 7) x = 8'h40;
            else x = 8'h00;
            push_frame(1'(f % 2), x, 1'b0, -1, 8'h00);
        end
        run_scenario("fas_loss", 1, fs, dr);
        check_val("loss_sync_bit", 32'(fs), 32'd519);
        check_val("loss_drop_bit", 32'(dr), 32'd3591);

        // gapped bit_en, one cycle in four
        bit_q.delete();
        for (int f = 0; f < 8; f++) push_frame(1'(f % 2), 8'h00, 1'b0, -1, 8'h00);
        run_scenario("gap4", 4, fs, dr);
        check_val("gap4_sync_bit", 32'(fs), 32'd519);

        // random payload, random prefix, random corruption, random gaps
        for (int r = 0; r < 2; r++) begin
            bit_q.delete();
            plen = $urandom_range(0, 40);
            repeat (plen) bit_q.push_back(1'($urandom));
            for (int f = 0; f < 12; f++) begin
                if ($urandom_range(0, 5) == 0)
                    x = (f % 2 == 1) ? 8'h40 : 8'(8'h01 << $urandom_range(0, 6));
                else
                    x = 8'h00;
                push_frame(1'(f % 2), x, 1'b1, -1, 8'h00);
            end
            run_scenario("random", 0, fs, dr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
